// File: rtl/multi_prescaler_if.sv
// Control and tick/done bundle for multi_prescaler.
// The master side drives enables, modes and period writes; the slave side returns ticks and done flags.
interface multi_prescaler_if #(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned CNT_WIDTH = 16
);
    logic [CHANNELS-1:0]  en;
    logic [CHANNELS-1:0]  mode;
    logic                 sync_clr;
    logic                 period_wr;
    logic [3:0]           period_sel;
    logic [CNT_WIDTH-1:0] period_data;
    logic [CHANNELS-1:0]  tick;
    logic [CHANNELS-1:0]  done;

    modport master (
        output en, mode, sync_clr, period_wr, period_sel, period_data,
        input  tick, done
    );

    modport slave (
        input  en, mode, sync_clr, period_wr, period_sel, period_data,
        output tick, done
    );
endinterface

// File: rtl/multi_prescaler.sv
// Multi-channel programmable tick generator: each channel ticks every period+1 cycles,
// free-running or one-shot, with runtime period writes and a shared counter restart.
module multi_prescaler #(
    parameter int unsigned          CHANNELS       = 4,
    parameter int unsigned          CNT_WIDTH      = 16,
    parameter logic [CNT_WIDTH-1:0] DEFAULT_PERIOD = CNT_WIDTH'(50000)
) (
    input  logic               clk,
    input  logic               rst,
    multi_prescaler_if.slave   bus
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        localparam logic [3:0] SEL = 4'(c);

        logic [CNT_WIDTH-1:0] cnt;
        logic [CNT_WIDTH-1:0] period;
        logic                 tick_q;
        logic                 done_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt    <= '0;
                period <= DEFAULT_PERIOD;
                tick_q <= 1'b0;
                done_q <= 1'b0;
            end else begin
                // Selects outside 0..CHANNELS-1 match no channel and are dropped.
                if (bus.period_wr && bus.period_sel == SEL) begin
                    period <= bus.period_data;
                end

                if (!bus.en[c]) begin
                    cnt    <= '0;
                    tick_q <= 1'b0;
                    done_q <= 1'b0;
                end else if (bus.sync_clr) begin
                    cnt    <= '0;
                    tick_q <= 1'b0;
                end else if (bus.mode[c] && done_q) begin
                    tick_q <= 1'b0;
                end else if (cnt < period) begin
                    cnt    <= cnt + 1'b1;
                    tick_q <= 1'b0;
                    // A halted one-shot switched to periodic lands here and drops done.
                    done_q <= 1'b0;
                end else begin
                    cnt    <= '0;
                    tick_q <= 1'b1;
                    done_q <= bus.mode[c];
                end
            end
        end

        assign bus.tick[c] = tick_q;
        assign bus.done[c] = done_q;
    end

endmodule

// File: tb/tb_multi_prescaler.sv
// Directed table-driven bench for multi_prescaler with 2 channels, 4-bit counters, default period 3.
module tb_multi_prescaler;

    typedef struct {
        logic       rst;
        logic [1:0] en;
        logic [1:0] mode;
        logic       sc;
        logic       wr;
        logic [3:0] sel;
        logic [3:0] data;
        logic [1:0] tick;
        logic [1:0] done;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   passed;
    vec_t vecs[$];

    multi_prescaler_if #(.CHANNELS(2), .CNT_WIDTH(4)) bus ();

    multi_prescaler #(
        .CHANNELS(2),
        .CNT_WIDTH(4),
        .DEFAULT_PERIOD(4'd3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void add(input logic r, input logic [1:0] e, input logic [1:0] m,
                                input logic s, input logic w, input logic [3:0] sl,
                                input logic [3:0] d, input logic [1:0] t, input logic [1:0] dn);
        vec_t v;
        v.rst = r; v.en = e; v.mode = m; v.sc = s; v.wr = w;
        v.sel = sl; v.data = d; v.tick = t; v.done = dn;
        vecs.push_back(v);
    endfunction

    // Apply one edge worth of inputs, then compare outputs 1 ns after the edge.
    task automatic step(input vec_t v, input string name);
        rst             = v.rst;
        bus.en          = v.en;
        bus.mode        = v.mode;
        bus.sync_clr    = v.sc;
        bus.period_wr   = v.wr;
        bus.period_sel  = v.sel;
        bus.period_data = v.data;
        @(posedge clk);
        #1;
        checks++;
        if (bus.tick !== v.tick || bus.done !== v.done)
            $display("FAIL %s: tick=%b done=%b, expected tick=%b done=%b",
                     name, bus.tick, bus.done, v.tick, v.done);
        else
            passed++;
    endtask

    task automatic run(input logic r, input logic [1:0] e, input logic [1:0] m,
                       input logic s, input logic w, input logic [3:0] sl,
                       input logic [3:0] d, input logic [1:0] t, input logic [1:0] dn,
                       input string name);
        vec_t v;
        v.rst = r; v.en = e; v.mode = m; v.sc = s; v.wr = w;
        v.sel = sl; v.data = d; v.tick = t; v.done = dn;
        step(v, name);
    endtask

    initial begin
        checks = 0;
        passed = 0;
        rst = 1'b1;
        bus.en = '0; bus.mode = '0; bus.sync_clr = 1'b0;
        bus.period_wr = 1'b0; bus.period_sel = '0; bus.period_data = '0;

        // Reset, reset overriding enable
        add(1, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00);
        add(1, 2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00);
        // Default period 3: tick after the 4th enabled edge, then every 4
        for (int i = 0; i < 8; i++)
            add(0, 2'b11, 2'b00, 0, 0, 0, 0, (i == 3 || i == 7) ? 2'b11 : 2'b00, 2'b00);
        // ch0 P=0, ch1 P=7, then P=9 written while ch1 cnt=5
        add(0, 2'b11, 2'b00, 0, 1, 4'd0, 4'd0, 2'b00, 2'b00);
        add(0, 2'b11, 2'b00, 0, 1, 4'd1, 4'd7, 2'b01, 2'b00);
        for (int i = 0; i < 3; i++)
            add(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b01, 2'b00);
        add(0, 2'b11, 2'b00, 0, 1, 4'd1, 4'd9, 2'b01, 2'b00);
        for (int i = 0; i < 3; i++)
            add(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b01, 2'b00);
        add(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b11, 2'b00);
        // Out-of-range write (sel=3) in the middle of the 10-cycle period
        for (int i = 0; i < 9; i++)
            add(0, 2'b11, 2'b00, 0, (i == 2), (i == 2) ? 4'd3 : 4'd0,
                (i == 2) ? 4'd15 : 4'd0, 2'b01, 2'b00);
        add(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b11, 2'b00);
        // ch1 one-shot P=2, halt, re-arm via en, then switch back to periodic
        add(0, 2'b00, 2'b10, 0, 1, 4'd1, 4'd2, 2'b00, 2'b00);
        add(0, 2'b10, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00);
        add(0, 2'b10, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00);
        add(0, 2'b10, 2'b10, 0, 0, 0, 0, 2'b10, 2'b10);
        add(0, 2'b10, 2'b10, 0, 0, 0, 0, 2'b00, 2'b10);
        add(0, 2'b10, 2'b10, 0, 0, 0, 0, 2'b00, 2'b10);
        add(0, 2'b00, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00);
        add(0, 2'b10, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00);
        add(0, 2'b10, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00);
        add(0, 2'b10, 2'b10, 0, 0, 0, 0, 2'b10, 2'b10);
        add(0, 2'b10, 2'b10, 0, 0, 0, 0, 2'b00, 2'b10);
        add(0, 2'b10, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00);
        add(0, 2'b10, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00);
        add(0, 2'b10, 2'b00, 0, 0, 0, 0, 2'b10, 2'b00);
        // Both P=3, ch0 advanced to cnt=2, then sync_clr aligns them
        add(0, 2'b00, 2'b00, 0, 1, 4'd0, 4'd3, 2'b00, 2'b00);
        add(0, 2'b00, 2'b00, 0, 1, 4'd1, 4'd3, 2'b00, 2'b00);
        add(0, 2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00);
        add(0, 2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00);
        add(0, 2'b11, 2'b00, 1, 0, 0, 0, 2'b00, 2'b00);
        for (int i = 0; i < 8; i++)
            add(0, 2'b11, 2'b00, 0, 0, 0, 0, (i == 3 || i == 7) ? 2'b11 : 2'b00, 2'b00);
        // sync_clr on the terminal-count edge suppresses the tick
        for (int i = 0; i < 8; i++)
            add(0, 2'b11, 2'b00, (i == 3), 0, 0, 0, (i == 7) ? 2'b11 : 2'b00, 2'b00);
        // ch0 P=1 written so cnt=3 already exceeds it
        add(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00);
        add(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00);
        add(0, 2'b11, 2'b00, 0, 1, 4'd0, 4'd1, 2'b00, 2'b00);
        add(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b11, 2'b00);
        add(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00);
        add(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b01, 2'b00);
        add(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00);
        add(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b11, 2'b00);
        add(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00);
        add(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b01, 2'b00);
        // ch1 one-shot fires, then reset mid-count restores default periods
        add(0, 2'b11, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00);
        add(0, 2'b11, 2'b10, 0, 0, 0, 0, 2'b11, 2'b10);
        add(0, 2'b11, 2'b10, 0, 0, 0, 0, 2'b00, 2'b10);
        add(1, 2'b11, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00);
        for (int i = 0; i < 4; i++)
            add(0, 2'b11, 2'b00, 0, 0, 0, 0, (i == 3) ? 2'b11 : 2'b00, 2'b00);

        foreach (vecs[i])
            step(vecs[i], $sformatf("vec%0d", i));

        // en dropped on ch1's terminal-count edge: only ch0 ticks
        for (int i = 0; i < 3; i++)
            run(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, $sformatf("en_tc_pre%0d", i));
        run(0, 2'b01, 2'b00, 0, 0, 0, 0, 2'b01, 2'b00, "en_tc_edge");

        // Write coincident with terminal count: old period governs, new one applies after
        for (int i = 0; i < 3; i++)
            run(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, $sformatf("wr_tc_pre%0d", i));
        run(0, 2'b11, 2'b00, 0, 1, 4'd0, 4'd9, 2'b11, 2'b00, "wr_tc_edge");
        for (int k = 1; k <= 10; k++)
            run(0, 2'b11, 2'b00, 0, 0, 0, 0,
                {(k == 4 || k == 8), (k == 10)}, 2'b00, $sformatf("wr_tc_post%0d", k));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/multi_prescaler.md
# multi_prescaler

Multi-channel, runtime-programmable tick generator, the parametrised successor to the single-channel fixed-period prescaler. Each channel divides the 100 MHz system clock by a per-channel period register, loadable at run time, and runs either free-running (periodic ticks) or one-shot (single tick, then halt). It feeds game-step, LED-refresh and input-debounce timing in the LED snake design from one shared block.

## Interface
Parameters:
- `CHANNELS`, 4: number of independent channels (1..16).
- `CNT_WIDTH`, 16: width of counters and period registers.
- `DEFAULT_PERIOD`, 16'd50000: reset value of every period register (tick every 50001 cycles).

Ports:
- `clk`  in  1  system clock, 100 MHz; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  CHANNELS  per-channel enable; low holds the channel cleared.
- `mode`  in  CHANNELS  per-channel mode: 0 periodic, 1 one-shot.
- `sync_clr`  in  1  one-cycle strobe; restarts all enabled channels' counters together.
- `period_wr`  in  1  period write strobe.
- `period_sel`  in  4  channel index for the write.
- `period_data`  in  CNT_WIDTH  new period value P.
- `tick`  out  CHANNELS  registered one-cycle tick pulses.
- `done`  out  CHANNELS  registered; one-shot channel has fired and halted.

## Operation
- Reset (`rst`=1 at an edge): all `cnt` to 0, `tick` to 0, `done` to 0, all period registers to `DEFAULT_PERIOD`. Reset overrides every other input.
- Period write: on an edge with `period_wr`=1 and `period_sel` < CHANNELS, `period[period_sel]` <= `period_data`. Writes with `period_sel` >= CHANNELS are ignored. No effect on `cnt`.
- Per channel c at each edge, in priority order:
  1. `en[c]`=0: `cnt`<=0, `tick`<=0, `done`<=0.
  2. `sync_clr`=1: `cnt`<=0, `tick`<=0. `done` is unchanged.
  3. `mode[c]`=1 and `done[c]`=1: hold, with `tick`<=0.
  4. `cnt` < `period[c]`: `cnt`<=`cnt`+1, `tick`<=0.
  5. Otherwise (`cnt` >= `period[c]`): `cnt`<=0, `tick`<=1. If `mode[c]`=1, also `done`<=1.
- Comparison is unsigned, full CNT_WIDTH. `cnt` never exceeds the maximum of `period[c]` and its previous value, so there is no overflow.
- Mode change while running:
  - Periodic to one-shot: takes effect at the next terminal count.
  - One-shot with `done`=1 switched to periodic: `done`<=0 and counting resumes from 0 at the next edge.
- Re-arming a one-shot: deassert `en[c]` for at least one cycle.

## Timing
- Period semantics: a period value P gives one tick every P+1 cycles. P=0 gives `tick` high on every cycle while enabled.
- Start-up latency: let edge 0 be the first edge with `en[c]`=1 after `cnt`=0. `tick[c]` is high during the cycle after edge P, for exactly one cycle.
- Period write latency: the new value is used in the comparison from the edge after the write edge.
  - If the current `cnt` is already >= the new P, the channel ticks at the next edge and wraps to 0.
- A write to channel c in the same cycle as that channel's terminal count: the old period governs that edge.
- `sync_clr`: after the strobe edge, all enabled channels are at `cnt`=0. Channels with equal P tick on the same cycle thereafter.
  - `sync_clr` coincident with a terminal count suppresses that tick.
- Simultaneous `en[c]`=0 and terminal count: `en` wins, so there is no tick.
- Reset mid-count: outputs are 0 in the cycle after the reset edge. Counting restarts from 0 using `DEFAULT_PERIOD`.

## Test plan
Bench configuration: CHANNELS=2, CNT_WIDTH=4, DEFAULT_PERIOD=4'd3.
- Reset release, then `en`=2'b11 with `mode`=0 -> both channels tick every 4 cycles; the first tick is in the cycle after the 4th enabled edge; `done`=0 throughout.
- Write P=0 to ch0, and P=9 to ch1 while ch1's `cnt`=5 -> ch0 ticks every cycle; ch1 next ticks 5 cycles later, then every 10 cycles. Write of P=15 with `period_sel`=3 -> no change on either channel.
- ch1 `mode`=1 with P=2 -> exactly one tick after 3 cycles, `done[1]`=1 and held. Drop `en[1]` for one cycle, then raise it -> `done` clears and a single tick follows 3 cycles later.
- ch0 at `cnt`=2 and ch1 at `cnt`=0, both with P=3, then pulse `sync_clr` -> both channels tick together on every 4th cycle afterwards. `sync_clr` on a terminal-count edge -> that tick is absent.
- Write ch0 P=1 while ch0's `cnt`=3 -> tick at the next edge, then every 2 cycles.
- Assert `rst` mid-count with a one-shot `done`=1 -> `tick`=0 and `done`=0 next cycle; period registers read back as 3 (ticks every 4 cycles).
